// File: rtl/tia_color_lum_capture.sv
// rtl/tia_color_lum_capture.sv - groups visible TIA lum/color pixels into sol/eol tagged words behind a FWFT FIFO
// One-pixel hold stage lets each pixel learn its end-of-line status before it is queued.
module tia_color_lum_capture #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clkp,
  input  logic              reset_bar,
  input  logic              blk_bar,
  input  logic              l0,
  input  logic              l1,
  input  logic              l2,
  input  logic              c0,
  input  logic              c1,
  input  logic              c2,
  input  logic              c3,
  input  logic              out_ready,
  input  logic              clear_ovf,
  output logic              out_valid,
  output logic [6:0]        out_data,
  output logic [7:0]        out_x,
  output logic              out_sol,
  output logic              out_eol,
  output logic              overflow,
  output logic [8:0]        line_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [6:0] data;
    logic [7:0] x;
    logic       sol;
    logic       eol;
  } word_t;

  logic              h_valid;
  logic [6:0]        h_data;
  logic [7:0]        h_x;
  logic              h_sol;
  logic              prev_vis;
  logic [7:0]        xcnt;

  word_t             mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;

  logic [6:0]        pix;
  logic [7:0]        x_new;
  word_t             push_word;
  word_t             head_next;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              full;

  assign pix       = {c3, c2, c1, c0, l2, l1, l0};
  assign x_new     = !prev_vis ? 8'd0 : (xcnt == 8'hFF) ? 8'hFF : xcnt + 8'd1;

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid && out_ready;
  assign push_req  = h_valid;
  assign push_ok   = push_req && (!full || pop);

  assign push_word = '{data: h_data, x: h_x, sol: h_sol, eol: !blk_bar};

  assign rd_next    = rd_ptr + ADDR_W'(pop);
  assign count_next = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop);

  // Registered head: bypass the word being written when it becomes the new head.
  always_comb begin
    head_next = mem[rd_next];
    if (push_ok && (rd_next == wr_ptr)) begin
      head_next = push_word;
    end
  end

  always_ff @(posedge clkp) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      out_x    <= '0;
      out_sol  <= 1'b0;
      out_eol  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        out_data <= head_next.data;
        out_x    <= head_next.x;
        out_sol  <= head_next.sol;
        out_eol  <= head_next.eol;
      end
    end
  end

  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      h_valid    <= 1'b0;
      h_data     <= '0;
      h_x        <= '0;
      h_sol      <= 1'b0;
      prev_vis   <= 1'b0;
      xcnt       <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_vis <= blk_bar;
      if (blk_bar) begin
        xcnt    <= x_new;
        h_data  <= pix;
        h_x     <= x_new;
        h_sol   <= !prev_vis;
        h_valid <= 1'b1;
      end else begin
        xcnt <= '0;
        // The run closes here even if its final word is dropped.
        if (h_valid) begin
          h_valid    <= 1'b0;
          line_count <= line_count + 9'd1;
        end
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tia_color_lum_capture.md
# tia_color_lum_capture

Receiving end of the color/luminance output of `tia_color_lum_registers`. It samples the 7-bit lum/color pixel stream and `blk_bar` on every `clkp` rising edge and groups visible pixels into line-delimited packets. Packets are buffered in a small FIFO and presented on a valid/ready stream port. It sits between the TIA color path and downstream frame capture or comparison logic, such as a scoring or bench model.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO depth in entries. Must be a power of two, at least 2.
- `ADDR_W`, default 3: log2(`DEPTH`).

Ports:
- `clkp`, input, 1: pixel clock. All state updates on the rising edge.
- `reset_bar`, input, 1: asynchronous, active-low reset.
- `blk_bar`, input, 1: 1 means the current pixel is visible; 0 means blanking.
- `l0`, `l1`, `l2`, input, 1 each: luminance bits, LSB first.
- `c0`, `c1`, `c2`, `c3`, input, 1 each: color bits, LSB first.
- `out_ready`, input, 1: consumer accepts the word on this edge.
- `clear_ovf`, input, 1: synchronous clear of `overflow`.
- `out_valid`, output, 1: FIFO head is valid.
- `out_data`, output, 7: `{c3,c2,c1,c0,l2,l1,l0}`, bit 0 is `l0`.
- `out_x`, output, 8: pixel index within the visible run.
- `out_sol`, output, 1: first pixel of the run.
- `out_eol`, output, 1: last pixel of the run.
- `overflow`, output, 1: sticky flag, set when a push was dropped.
- `line_count`, output, 9: count of completed visible runs.

## Operation
- Hold stage H holds `h_valid`, `h_data`, `h_x` and `h_sol`. It delays each pixel one edge so that the pixel's end-of-line status is known before it is pushed.
- Internal `prev_vis` is `blk_bar` registered from the previous edge. Internal `xcnt` is 8 bits.
- On an edge where `blk_bar`=1:
  - The new pixel gets x = `prev_vis` ? sat255(`xcnt`+1) : 0. `xcnt` takes this value.
  - The new pixel gets sol = !`prev_vis`.
  - If `h_valid`=1, push H with eol=0.
  - Load H with the new pixel and set `h_valid`=1.
- On an edge where `blk_bar`=0:
  - If `h_valid`=1, push H with eol=1, set `h_valid`=0, and increment `line_count`. `line_count` wraps from 511 to 0 and increments even if the push is dropped.
  - `xcnt` is set to 0.
- `x` saturates at 255. Pixels beyond index 255 repeat x=255.
- Push rules:
  - A push succeeds if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the word is discarded and `overflow` is set to 1.
- Pop occurs when `out_valid` and `out_ready` are both 1. A pop and a push on the same edge are both honored, and the occupancy count is unchanged.
- The FIFO is first-word-fall-through. The `out_*` fields reflect the head entry whenever `out_valid`=1. When `out_valid`=0 the fields are don't-care and hold their last value.
- `clear_ovf`=1 clears `overflow` on the edge. If a drop happens on the same edge, `overflow` ends at 1 (set wins).
- Asynchronous reset while `reset_bar`=0:
  - Cleared: `h_valid`, `prev_vis`, `xcnt`, FIFO pointers and count, `overflow`, `line_count`.
  - Outputs: `out_valid`=0, `out_data`=0, `out_x`=0, `out_sol`=0, `out_eol`=0, `overflow`=0, `line_count`=0.
  - A line in progress is discarded. The first visible pixel after release has sol=1 and x=0.

## Timing
- A pixel sampled at edge N enters H at N.
- It is pushed at edge N+1, when the next pixel or the blank is sampled.
- `out_valid` rises after edge N+1, if the FIFO was empty. Latency from input to output is 2 edges.
- Throughput is one word per `clkp` edge with `out_ready` held at 1. The FIFO never fills under that condition.
- `out_eol` on the last pixel is produced by the edge that samples `blk_bar`=0. A line is therefore not closed until blanking is seen.
- Combinational inputs-to-outputs paths: none. `out_valid` does not depend on `out_ready` within a cycle.

## Test plan
1. Reset check: drive `reset_bar`=0 mid-stream. Required response: `out_valid`=0, `overflow`=0, `line_count`=0. After release, a new run starts with sol=1 and x=0.
2. Basic line, `out_ready`=1: 3 visible pixels with data 0x70, 0x55, 0x2A, then blank. Required response: 3 words with x=0, 1, 2. sol is set on the first word only. eol is set on the third word only. `line_count`=1. The first word appears 2 edges after it is sampled.
3. Single-pixel run, data 0x7F, then blank. Required response: one word with x=0, sol=1, eol=1.
4. Backpressure, `DEPTH`=8, `out_ready`=0: 12 visible pixels, then blank. Required response:
   - Pixels 0–7 are stored. Pixels 8–11 are dropped, including the eol on pixel 11.
   - `overflow`=1 and `line_count`=1.
   - Then `out_ready`=1 drains 8 words with x=0..7 and no eol. `clear_ovf` then clears `overflow` to 0.
5. Simultaneous events: with the FIFO full, apply a pop and a push on the same edge. Required response: no drop, occupancy stays at 8. Separately, apply `clear_ovf`=1 on an edge that drops. Required response: `overflow` stays 1.
6. Saturation: 300 visible pixels with `out_ready`=1. Required response: x runs 0..255, then x=255 for the remaining 44 words. eol=1 only on the 300th word.
